uint_to_l3: RTL and testbench
=============================

UINT_TO_L3 -- requirements
Module: uint_to_l3

Interface
REQ-001 SHALL take no parameters; all widths come from PARAMS_BN254_d0: W = $bits(fp_div4_t), L3_CARRY, ADD_DIV = 4, LEN_12M_TILDE = 4*W, M_tilde.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  din holds a valid operand.
REQ-005 in_ready  output  1  block accepts din this cycle.
REQ-006 din  input  LEN_12M_TILDE+L3_CARRY  unsigned integer in the offset (plus M_tilde*512) domain.
REQ-007 out_valid  output  1  dout holds a valid result.
REQ-008 out_ready  input  1  downstream accepts dout this cycle.
REQ-009 dout  output  redundant_poly_L3  canonical redundant-L3 encoding of din minus M_tilde512.

Function
REQ-010 Constant: M_tilde512 = {M_tilde, 9'd0}, viewed as fp_div4_t limbs m[0..4]; top constant mt = {m[4], m[3]} truncated to W+L3_CARRY bits.
REQ-011 Split: d[i] = din[(i+1)*W-1 : i*W] for i = 0..2; dt = din[top W+L3_CARRY bits].
REQ-012 Result r = (din - M_tilde512) mod 2^(4W+L3_CARRY), computed as limb-serial subtraction with one borrow bit between limbs.
REQ-013 Stage 1: {b0, r0} = d[0] - m[0]; d[1..3] and dt skewed forward.
REQ-014 Stage 2: {b1, r1} = d[1] - m[1] - b0.
REQ-015 Stage 3: {b2, r2} = d[2] - m[2] - b1.
REQ-016 Stage 4: rt = dt - mt - b2, width W+L3_CARRY, wraps modulo 2^(W+L3_CARRY).
REQ-017 Output mapping: dout[i].val = r_i and dout[i].carry = 0 for i = 0..2; dout[3].val = rt[W-1:0]; dout[3].carry = rt[W+L3_CARRY-1:W].
REQ-018 Latency: exactly 4 clk cycles from accepting handshake (in_valid and in_ready) to out_valid, when out_ready is held high.
REQ-019 Throughput: one operand per cycle; back-to-back operands produce back-to-back results in order.
REQ-020 Pipeline advance: adv = out_ready or not out_valid; all 4 stages and their valid bits shift only when adv = 1.
REQ-021 in_ready = adv, combinational, with no dependency on in_valid.
REQ-022 Stall: while out_valid = 1 and out_ready = 0, dout and out_valid hold and no stage changes.
REQ-023 Bubbles: an empty stage shifts forward as a cleared valid bit; bubble data is don't-care but dout SHALL be stable while out_valid = 1.
REQ-024 Simultaneous events: when adv = 1, an output transfer and an input acceptance in the same cycle are both completed.
REQ-025 Sign: a borrow out of rt is discarded; a negative result shows as dout[3].carry MSB = 1, which L3touint interprets as sign.
REQ-026 Round trip: L3touint(uint_to_l3(x)) SHALL equal x for every x < 2^(4W+L3_CARRY).

Reset
REQ-027 When rst = 1 at a clk edge, all stage valid bits and out_valid SHALL be 0, and dout SHALL be all-zero on the next cycle.
REQ-028 Reset SHALL override any handshake in the same cycle; in-flight operands are discarded without emission.
REQ-029 in_ready SHALL be 1 in the first cycle after reset.

Verification
REQ-030 din = M_tilde512 truncated, out_ready = 1 -> 4 cycles later out_valid = 1 and all val and carry fields are 0.
REQ-031 din = 0 -> dout equals the limb split of 2^(4W+L3_CARRY) - M_tilde512; dout[3].carry MSB = 1; carries 0..2 are 0.
REQ-032 Five back-to-back operands x, x+1, ..., x+4 with out_ready = 1 -> five consecutive out_valid cycles, in order, each matching REQ-012.
REQ-033 out_ready = 0 for 3 cycles while out_valid = 1 -> dout is bit-stable, in_ready = 0, and no result is lost or duplicated after release.
REQ-034 Assert rst for 1 cycle with 3 operands in flight -> out_valid = 0 for the next 4 cycles and no stale result is emitted.
REQ-035 Random x with random out_ready, fed through L3touint -> output equals x for 10^4 samples, including 0, all-ones, and a borrow chain through limbs 0..2.

Source files
------------

// File: rtl/uint_to_l3.sv
// uint_to_l3: converts an offset-domain unsigned integer to canonical redundant-L3 limbs
// by subtracting M_tilde*512 in a 4-stage limb-serial borrow pipeline.
package PARAMS_BN254_d0;
    typedef logic [63:0] fp_div4_t;
    localparam int W = $bits(fp_div4_t);
    localparam int L3_CARRY = 4;
    localparam int ADD_DIV = 4;
    localparam int LEN_12M_TILDE = 4 * W;
    localparam logic [LEN_12M_TILDE-1:0] M_tilde =
        256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;
    localparam logic [5*W-1:0] M_TILDE512 = {{(5*W-LEN_12M_TILDE-9){1'b0}}, M_tilde, 9'd0};
    typedef struct packed {
        logic [L3_CARRY-1:0] carry;
        fp_div4_t            val;
    } l3_limb_t;
    typedef l3_limb_t [3:0] redundant_poly_L3;
endpackage

module uint_to_l3
    import PARAMS_BN254_d0::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LEN_12M_TILDE+L3_CARRY-1:0] din,
    output logic                            out_valid,
    input  logic                            out_ready,
    output redundant_poly_L3                dout
);
    localparam int WT = W + L3_CARRY;
    localparam fp_div4_t M0 = M_TILDE512[W-1:0];
    localparam fp_div4_t M1 = M_TILDE512[2*W-1:W];
    localparam fp_div4_t M2 = M_TILDE512[3*W-1:2*W];
    localparam logic [WT-1:0] MT = M_TILDE512[3*W +: WT];

    logic             adv;
    logic [3:0]       v_q;
    // {borrow, difference} of each limb stage
    logic [W:0]       s1_d, s2_d, s3_d, s1_q, s2_q, s3_q;
    logic [WT-1:0]    rt_d;
    fp_div4_t         s1_d1_q, s1_d2_q, s2_r0_q, s2_d2_q, s3_r0_q, s3_r1_q;
    logic [WT-1:0]    s1_dt_q, s2_dt_q, s3_dt_q;
    redundant_poly_L3 dout_q, dout_d;

    assign adv       = out_ready | ~v_q[3];
    assign in_ready  = adv;
    assign out_valid = v_q[3];
    assign dout      = dout_q;

    always_comb begin
        s1_d = {1'b0, din[W-1:0]} - {1'b0, M0};
        s2_d = {1'b0, s1_d1_q} - {1'b0, M1} - {{W{1'b0}}, s1_q[W]};
        s3_d = {1'b0, s2_d2_q} - {1'b0, M2} - {{W{1'b0}}, s2_q[W]};
        rt_d = s3_dt_q - MT - {{(WT-1){1'b0}}, s3_q[W]};
        dout_d          = '0;
        dout_d[0].val   = s3_r0_q;
        dout_d[1].val   = s3_r1_q;
        dout_d[2].val   = s3_q[W-1:0];
        dout_d[3].val   = rt_d[W-1:0];
        dout_d[3].carry = rt_d[WT-1:W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q     <= '0;
            s1_q    <= '0;
            s1_d1_q <= '0;
            s1_d2_q <= '0;
            s1_dt_q <= '0;
            s2_q    <= '0;
            s2_r0_q <= '0;
            s2_d2_q <= '0;
            s2_dt_q <= '0;
            s3_q    <= '0;
            s3_r0_q <= '0;
            s3_r1_q <= '0;
            s3_dt_q <= '0;
            dout_q  <= '0;
        end else if (adv) begin
            v_q     <= {v_q[2:0], in_valid};
            s1_q    <= s1_d;
            s1_d1_q <= din[2*W-1:W];
            s1_d2_q <= din[3*W-1:2*W];
            s1_dt_q <= din[LEN_12M_TILDE+L3_CARRY-1:3*W];
            s2_q    <= s2_d;
            s2_r0_q <= s1_q[W-1:0];
            s2_d2_q <= s1_d2_q;
            s2_dt_q <= s1_dt_q;
            s3_q    <= s3_d;
            s3_r0_q <= s2_r0_q;
            s3_r1_q <= s2_q[W-1:0];
            s3_dt_q <= s2_dt_q;
            dout_q  <= dout_d;
        end
    end
endmodule

// File: tb/tb_uint_to_l3.sv
// tb_uint_to_l3: directed and random stimulus with a scoreboard comparing every result
// against a full-width subtraction model and a reconstruction back to the input.
module tb_uint_to_l3;
    import PARAMS_BN254_d0::*;
    localparam int DW = LEN_12M_TILDE + L3_CARRY;
    localparam int OW = $bits(redundant_poly_L3);
    localparam int N  = 10000;
    localparam logic [DW-1:0] M512T = M_TILDE512[DW-1:0];

    typedef struct packed {
        logic [DW-1:0] x;
        logic [OW-1:0] e;
    } item_t;

    logic             clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0]    din;
    redundant_poly_L3 dout;

    item_t         sb[$];
    item_t         it;
    int            n_cmp = 0;
    int            n_err = 0;
    int            lat, n, idx, cyc;
    logic          acc;
    logic [11:0]   ovs;
    logic [OW-1:0] held;
    logic [DW-1:0] x, bc;

    uint_to_l3 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [OW-1:0] model(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = v - M512T;
        return {r[DW-1:3*W], {L3_CARRY{1'b0}}, r[3*W-1:2*W],
                {L3_CARRY{1'b0}}, r[2*W-1:W], {L3_CARRY{1'b0}}, r[W-1:0]};
    endfunction

    function automatic logic [DW-1:0] l3touint(input redundant_poly_L3 d);
        logic [DW-1:0] a;
        a = M512T;
        for (int i = 0; i < 4; i++)
            a = a + (DW'(d[i].val) << (i*W)) + (DW'(d[i].carry) << ((i+1)*W));
        return a;
    endfunction

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) r = {r[DW-33:0], 32'($urandom())};
        return r;
    endfunction

    task automatic single(input logic [DW-1:0] v, output int l);
        in_valid = 1;
        din = v;
        @(posedge clk); #1;
        in_valid = 0;
        l = 1;
        while (!out_valid && l < 20) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic drain();
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 32'(sb.size()), 0);
    endtask

    always @(negedge clk) begin
        if (rst) sb.delete();
        else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("spurious_out", out_valid, 0);
                else begin
                    it = sb.pop_front();
                    chk("dout", dout, it.e);
                    chk("round_trip", l3touint(dout), it.x);
                end
            end
            if (in_valid && in_ready) sb.push_back('{x: din, e: model(din)});
        end
    end

    initial begin
        rst = 1;
        in_valid = 0;
        din = '0;
        out_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_in_ready", in_ready, 1);
        // exact offset gives an all-zero result
        single(M512T, lat);
        chk("lat_m512", lat, 4);
        chk("m512_zero", dout, 0);
        single('0, lat);
        chk("lat_zero", lat, 4);
        chk("zero_sign", dout[3].carry[L3_CARRY-1], 1);
        chk("zero_low_carries", {dout[0].carry, dout[1].carry, dout[2].carry}, 0);
        @(posedge clk); #1;
        x = rnd();
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 5);
            din = x + DW'(i);
            @(posedge clk); #1;
            ovs[i] = out_valid;
        end
        chk("burst_pattern", ovs, 12'h0F8);
        drain();
        // stall with a pending operand held off by in_ready
        for (int i = 0; i < 3; i++) begin
            in_valid = 1;
            din = rnd();
            @(posedge clk); #1;
        end
        in_valid = 0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stall_wait", out_valid, 1);
        out_ready = 0;
        in_valid = 1;
        din = rnd();
        held = dout;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_dout", dout, held);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
        end
        out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        drain();
        // reset with operands in flight
        for (int i = 0; i < 3; i++) begin
            in_valid = 1;
            din = rnd();
            @(posedge clk); #1;
        end
        rst = 1;
        din = rnd();
        @(posedge clk); #1;
        rst = 0;
        in_valid = 0;
        chk("flush_dout", dout, 0);
        chk("flush_in_ready", in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            chk("flush_out_valid", out_valid, 0);
            @(posedge clk); #1;
        end
        // random traffic, starting with zero, all-ones and a borrow chain
        bc = M512T;
        bc[W-1:0] = '0;
        idx = 0;
        cyc = 0;
        while (idx < N && cyc < 60000) begin
            x = (idx == 0) ? '0 : (idx == 1) ? '1 : (idx == 2) ? bc : rnd();
            in_valid = (idx < 3) || ($urandom_range(0, 7) != 0);
            din = x;
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) idx++;
        end
        chk("rand_done", idx, N);
        in_valid = 0;
        out_ready = 1;
        drain();
        chk("idle_out_valid", out_valid, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
